mod_inverse_sm: RTL and testbench

//   Computes the RSA private exponent d = e^-1 mod phi using the iterative extended Euclidean algorithm.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/divider_sm.sv | 78 +++++++
 rtl/mod_inverse_sm.sv | 167 ++++++++++++++++
 tb/tb_mod_inverse_sm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA key-generation types: operand width and modular-inverse FSM states.
package rsa_pkg;
    localparam int RSA_WIDTH = 32;

    typedef enum logic [2:0] {
        RESET,
        WAIT,
        LOAD,
        DIVIDE,
        MULT,
        UPDATE,
        FINAL,
        FINISHED
    } inv_state_t;
endpackage

// File: rtl/divider_sm.sv
// Restoring unsigned divider, one quotient bit per cycle; div_done pulses
// WIDTH+1 cycles after div_start is sampled, quot/rem then hold until next start.
module divider_sm #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             div_start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   rem_shift;

    // The dividend bits leave the top of quot_q as quotient bits enter at the bottom.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        den_d  = den_q;
        done_d = 1'b0;
        if (div_start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(WIDTH);
            quot_d = num;
            rem_d  = '0;
            den_d  = den;
        end else if (busy_q) begin
            if (rem_shift >= {1'b0, den_q}) begin
                rem_d  = WIDTH'(rem_shift - {1'b0, den_q});
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = rem_shift[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            done_q <= done_d;
        end
    end

    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_done = done_q;
endmodule

// File: rtl/mod_inverse_sm.sv
// Computes d = e^-1 mod phi with the iterative extended Euclidean algorithm:
// serial divide, serial shift-add multiply, then register update per iteration.
module mod_inverse_sm
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inv_ready,
    input  logic [WIDTH-1:0] phi_in,
    input  logic [WIDTH-1:0] e_in,
    output logic [WIDTH-1:0] d_out,
    output logic             inv_done,
    output logic             inv_error
);
    localparam int CW = $clog2(WIDTH + 1);

    inv_state_t              state_q, state_d;
    logic [WIDTH-1:0]        phi_q, phi_d;
    logic [WIDTH-1:0]        r0_q, r0_d, r1_q, r1_d;
    logic signed [WIDTH:0]   t0_q, t0_d, t1_q, t1_d;
    logic [WIDTH-1:0]        q_q, q_d, rem_q, rem_d;
    logic signed [WIDTH:0]   mcand_q, mcand_d, p_q, p_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    div_busy_q, div_busy_d;
    logic [WIDTH-1:0]        d_q, d_d;
    logic                    err_q, err_d, done_q, done_d;
    logic                    div_start, div_done;
    logic [WIDTH-1:0]        div_quot, div_rem;
    logic signed [WIDTH:0]   t0_wrap;

    assign t0_wrap = t0_q + $signed({1'b0, phi_q});

    divider_sm #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .div_start(div_start),
        .num      (r0_q),
        .den      (r1_q),
        .quot     (div_quot),
        .rem      (div_rem),
        .div_done (div_done)
    );

    always_comb begin
        state_d    = state_q;
        phi_d      = phi_q;
        r0_d       = r0_q;
        r1_d       = r1_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        q_d        = q_q;
        rem_d      = rem_q;
        mcand_d    = mcand_q;
        p_d        = p_q;
        bit_cnt_d  = bit_cnt_q;
        div_busy_d = div_busy_q;
        d_d        = d_q;
        err_d      = err_q;
        done_d     = done_q;
        div_start  = 1'b0;
        case (state_q)
            RESET: state_d = WAIT;
            WAIT: if (inv_ready) state_d = LOAD;
            LOAD: begin
                phi_d = phi_in;
                r0_d  = phi_in;
                r1_d  = e_in;
                t0_d  = '0;
                t1_d  = {{WIDTH{1'b0}}, 1'b1};
                if (phi_in == '0 || e_in == '0) begin
                    // r0 = 0 makes FINAL report "no inverse" regardless of the other operand.
                    r0_d    = '0;
                    state_d = FINAL;
                end else begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (!div_busy_q) begin
                    div_start  = 1'b1;
                    div_busy_d = 1'b1;
                end else if (div_done) begin
                    div_busy_d = 1'b0;
                    q_d        = div_quot;
                    rem_d      = div_rem;
                    mcand_d    = t1_q;
                    p_d        = '0;
                    bit_cnt_d  = CW'(WIDTH);
                    state_d    = MULT;
                end
            end
            MULT: begin
                // Two's-complement wrap in p/mcand is harmless: the true product fits in WIDTH+1 bits.
                if (q_q[0]) p_d = p_q + mcand_q;
                mcand_d   = mcand_q <<< 1;
                q_d       = q_q >> 1;
                bit_cnt_d = bit_cnt_q - CW'(1);
                if (bit_cnt_q == CW'(1)) state_d = UPDATE;
            end
            UPDATE: begin
                r0_d    = r1_q;
                r1_d    = rem_q;
                t0_d    = t1_q;
                t1_d    = t0_q - p_q;
                state_d = (rem_q == '0) ? FINAL : DIVIDE;
            end
            FINAL: begin
                err_d = (r0_q != WIDTH'(1));
                if (r0_q != WIDTH'(1)) d_d = '0;
                else if (t0_q[WIDTH])  d_d = t0_wrap[WIDTH-1:0];
                else                   d_d = t0_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = FINISHED;
            end
            FINISHED: begin
                if (!inv_ready) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET;
            phi_q      <= '0;
            r0_q       <= '0;
            r1_q       <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            mcand_q    <= '0;
            p_q        <= '0;
            bit_cnt_q  <= '0;
            div_busy_q <= 1'b0;
            d_q        <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phi_q      <= phi_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            mcand_q    <= mcand_d;
            p_q        <= p_d;
            bit_cnt_q  <= bit_cnt_d;
            div_busy_q <= div_busy_d;
            d_q        <= d_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign d_out     = d_q;
    assign inv_done  = done_q;
    assign inv_error = err_q;
endmodule

// File: tb/tb_mod_inverse_sm.sv
// Self-checking bench for mod_inverse_sm: directed vector table, reset-in-MULT
// sequence, and random coprime pairs against an extended-Euclid model.
module tb_mod_inverse_sm;
    localparam int W       = 32;
    localparam int TIMEOUT = 4000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         inv_ready = 1'b0;
    logic [W-1:0] phi_in = '0;
    logic [W-1:0] e_in = '0;
    logic [W-1:0] d_out;
    logic         inv_done;
    logic         inv_error;

    int n_checks = 0;
    int n_fail   = 0;

    mod_inverse_sm #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .inv_ready(inv_ready),
        .phi_in   (phi_in),
        .e_in     (e_in),
        .d_out    (d_out),
        .inv_done (inv_done),
        .inv_error(inv_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] phi;
        logic [W-1:0] e;
        logic [W-1:0] exp_d;
        logic         exp_err;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Plain extended Euclid on 64-bit integers; also reports the number of divisions.
    function automatic void model(input longint unsigned phi, input longint unsigned e,
                                  output longint unsigned d, output bit err, output int iters);
        longint r0, r1, t0, t1, q, rm, tn;
        iters = 0;
        if (phi == 0 || e == 0) begin
            d = 0; err = 1'b1; return;
        end
        r0 = longint'(phi); r1 = longint'(e); t0 = 0; t1 = 1;
        while (r1 != 0) begin
            q  = r0 / r1;
            rm = r0 % r1;
            tn = t0 - q * t1;
            r0 = r1; r1 = rm; t0 = t1; t1 = tn;
            iters++;
        end
        err = (r0 != 1);
        if (err)         d = 0;
        else if (t0 < 0) d = longint'(t0 + longint'(phi));
        else             d = longint'(t0);
    endfunction

    function automatic longint unsigned gcd(input longint unsigned a, input longint unsigned b);
        longint unsigned x = a, y = b, t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Raise the request, scramble the inputs after LOAD, and wait (bounded) for inv_done.
    task automatic run_req(input logic [W-1:0] phi, input logic [W-1:0] e, output int cyc);
        @(negedge clk);
        phi_in = phi; e_in = e; inv_ready = 1'b1; cyc = 0;
        while (!inv_done && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                phi_in = $urandom; e_in = $urandom;
            end
        end
        if (!inv_done) check("timeout_inv_done", inv_done, 1);
    endtask

    task automatic drop_ready();
        inv_ready = 1'b0;
        @(negedge clk);
        check("done_cleared", inv_done, 0);
        check("error_cleared", inv_error, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int cyc;
        longint unsigned md;
        bit merr;
        int mit;
        logic [W-1:0] held_d;
        logic [W-1:0] rphi, re;

        vecs[0] = '{phi: 3120, e: 17, exp_d: 2753, exp_err: 1'b0};
        vecs[1] = '{phi: 40,   e: 7,  exp_d: 23,   exp_err: 1'b0};
        vecs[2] = '{phi: 3120, e: 12, exp_d: 0,    exp_err: 1'b1};
        vecs[3] = '{phi: 0,    e: 5,  exp_d: 0,    exp_err: 1'b1};
        vecs[4] = '{phi: 40,   e: 0,  exp_d: 0,    exp_err: 1'b1};
        vecs[5] = '{phi: 40,   e: 1,  exp_d: 1,    exp_err: 1'b0};
        vecs[6] = '{phi: 40,   e: 47, exp_d: 23,   exp_err: 1'b0};

        repeat (3) @(negedge clk);
        check("reset_d_out", d_out, 0);
        check("reset_inv_done", inv_done, 0);
        check("reset_inv_error", inv_error, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_req(vecs[i].phi, vecs[i].e, cyc);
            $display("vec %0d: phi=%0d e=%0d -> d=%0d err=%0d done=%0d after %0d cycles",
                     i, vecs[i].phi, vecs[i].e, d_out, inv_error, inv_done, cyc);
            check("vec_d_out", d_out, vecs[i].exp_d);
            check("vec_inv_error", inv_error, vecs[i].exp_err);
            held_d = vecs[i].exp_d;
            repeat (10) begin
                @(negedge clk);
                check("hold_d_out", d_out, held_d);
                check("hold_inv_done", inv_done, 1);
            end
            drop_ready();
            check("d_out_kept_after_drop", d_out, held_d);
        end

        // Reset asserted while the first iteration is in its multiply phase.
        @(negedge clk);
        phi_in = 3120; e_in = 17; inv_ready = 1'b1;
        repeat (45) @(negedge clk);
        reset_n = 1'b0;
        #1;
        $display("reset in MULT: d=%0d done=%0d err=%0d", d_out, inv_done, inv_error);
        check("async_reset_d_out", d_out, 0);
        check("async_reset_inv_done", inv_done, 0);
        check("async_reset_inv_error", inv_error, 0);
        @(negedge clk);
        inv_ready = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_req(3120, 17, cyc);
        $display("after reset: phi=3120 e=17 -> d=%0d err=%0d cycles=%0d", d_out, inv_error, cyc);
        check("rerun_d_out", d_out, 2753);
        check("rerun_inv_error", inv_error, 0);
        drop_ready();

        for (int n = 0; n < 40; n++) begin
            do begin
                rphi = $urandom;
                re   = (n % 4 == 0) ? W'(65537) : W'($urandom);
            end while (rphi < 2 || re == 0 || gcd(rphi, re) != 1);
            model(rphi, re, md, merr, mit);
            run_req(rphi, re, cyc);
            $display("rand %0d: phi=%0d e=%0d -> d=%0d err=%0d cycles=%0d iters=%0d",
                     n, rphi, re, d_out, inv_error, cyc, mit);
            check("rand_d_out", d_out, md);
            check("rand_inv_error", inv_error, 0);
            check("rand_d_lt_phi", (d_out < rphi), 1);
            check("rand_ed_mod_phi", (longint'(re) * longint'(d_out)) % longint'(rphi), 1);
            check("rand_latency_in_bound", (cyc <= mit * (2 * W + 4) + 3), 1);
            drop_ready();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
